serial_crc_ccitt_checker: RTL
=============================

// Module: serial_crc_ccitt_checker
// PURPOSE
//  Receive-side partner of serial_crc_ccitt. Takes a bit-serial frame, MSB-first: payload bits
//  followed by the 16-bit FCS that the generator produced.
//  Runs the same CRC-CCITT LFSR over payload+FCS and checks for a zero residue.
//  Reports pass/fail plus a frame-length check. Sits after the serial deserializer/line receiver
//  and feeds frame accept/drop logic.
// PARAMETERS
//  init_value  16'h0000  LFSR preload at reset/start; must match the transmitting generator
//  POLY        16'h1021  CRC polynomial, x^16+x^12+x^5+1
//  CNT_W       16        width of bit_count; count saturates at 2^CNT_W-1
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  start      in   1      1-cycle pulse: preload LFSR, clear count/status, enter RUN
//  enable     in   1      bit strobe: m is valid this cycle
//  m          in   1      serial data bit, MSB-first (payload, then FCS[15]..FCS[0])
//  last       in   1      qualifies enable: this bit is the final FCS bit of the frame
//  busy       out  1      1 while in RUN
//  done       out  1      1-cycle pulse: frame verdict valid
//  crc_ok     out  1      sticky until next start/reset: residue==0 and length legal
//  crc_err    out  1      sticky until next start/reset: residue!=0 or length illegal
//  length_err out  1      sticky: frame shorter than 17 bits or bit_count saturated
//  bit_count  out  CNT_W  bits accepted in current frame, FCS included
//  crc_out    out  16     live LFSR contents
// BEHAVIOUR
//  Reset (async): state=IDLE; crc_out=init_value; bit_count=0; busy, done, crc_ok, crc_err and length_err all 0.
//  LFSR update per accepted bit, identical to the generator:
//    fb=crc[15]^m; crc<={crc[14:0],1'b0} ^ (fb ? POLY : 16'h0).
//    Feeding a correct FCS MSB-first leaves crc==16'h0000 for any init_value.
//  FSM: IDLE -> RUN on start. RUN -> DONE on enable&last. DONE -> IDLE next cycle,
//    or DONE -> RUN if start is high in that cycle.
//  IDLE: enable/m/last ignored; crc_out and bit_count hold.
//  start (any state): crc<=init_value, bit_count<=0, status<=0, state<=RUN.
//    An enable in the same cycle is dropped.
//  RUN, enable=1: LFSR updates and bit_count increments (saturating); enable=0 holds all.
//    Gaps of any length are allowed.
//  start during RUN: frame aborted, no done pulse, restart as above.
//  enable&last in RUN: the bit is consumed, then next cycle (DONE) done=1 and status registers load:
//    length_err = (bit_count<17) | saturated;
//    crc_ok = (crc==0) & ~length_err; crc_err = ~crc_ok.
//    Latency: verdict 1 cycle after the last bit's clock edge.
//  last without enable is ignored. enable&last in IDLE or DONE is ignored.
//  Exactly one of crc_ok/crc_err is 1 after any done, and both are 0 before the first done.
//  reset mid-frame: immediate return to reset values; no done.
// TESTING
//  T1 init 0x0000: start, bits 0x41 then FCS 0x58E5 (24 bits, last on bit 24)
//     -> done 1 cycle later, crc_ok=1, crc_err=0, bit_count=24, crc_out=0.
//  T2 init 0xFFFF: 0x41 then FCS 0xB915 -> crc_ok=1, crc_out=0. Same frame into an init 0x0000
//     instance -> crc_err=1.
//  T3 T1 with payload bit 3 inverted -> crc_err=1, length_err=0, crc_out!=0.
//  T4 runt: start, 10 bits with last on 10th -> done, crc_err=1, length_err=1.
//  T5 T1 with enable low for 3 cycles between every bit -> same result as T1.
//     Also: bits driven while IDLE leave crc_out at init_value.
//  T6 start after 12 bits of T1, then full T1 frame -> one done only, crc_ok=1, bit_count=24.
//     Also: reset asserted mid-frame -> all outputs back to reset values, no done.

Source files
------------

// File: rtl/serial_crc_ccitt_checker.sv
// Bit-serial CRC-CCITT frame checker: runs the generator's LFSR over payload+FCS and
// reports a zero-residue / legal-length verdict one cycle after the final FCS bit.
module serial_crc_ccitt_checker #(
    parameter logic [15:0] init_value = 16'h0000,
    parameter logic [15:0] POLY       = 16'h1021,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic             m,
    input  logic             last,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             length_err,
    output logic [CNT_W-1:0] bit_count,
    output logic [15:0]      crc_out,
    output logic [1:0]       o_dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Handshake: a bit is consumed on a rising edge where state is RUN, enable=1 and
    // start=0; last only matters on such an edge. done is high for the single DONE
    // cycle, and crc_ok/crc_err/length_err are valid whenever done is high.
    logic [1:0]       r_state;
    logic [15:0]      r_crc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ok;
    logic             r_err;
    logic             r_len;

    logic             w_accept;
    logic             w_fb;
    logic [15:0]      w_crc_next;
    logic [CNT_W-1:0] w_cnt_max;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_len_bad;
    logic             w_res_ok;

    assign w_accept   = (r_state == ST_RUN) & enable & ~start;
    assign w_fb       = r_crc[15] ^ m;
    assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_fb ? POLY : 16'h0000);
    assign w_cnt_max  = '1;
    assign w_cnt_next = (r_cnt == w_cnt_max) ? r_cnt : r_cnt + 1'b1;

    // Verdict is computed from the post-update values so it is ready in the DONE cycle.
    assign w_len_bad  = (w_cnt_next < CNT_W'(17)) | (w_cnt_next == w_cnt_max);
    assign w_res_ok   = (w_crc_next == 16'h0000) & ~w_len_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_crc   <= init_value;
            r_cnt   <= '0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_len   <= 1'b0;
        end else if (start) begin
            r_state <= ST_RUN;
            r_crc   <= init_value;
            r_cnt   <= '0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_len   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept) begin
                        r_crc <= w_crc_next;
                        r_cnt <= w_cnt_next;
                        if (last) begin
                            r_state <= ST_DONE;
                            r_ok    <= w_res_ok;
                            r_err   <= ~w_res_ok;
                            r_len   <= w_len_bad;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign crc_ok      = r_ok;
    assign crc_err     = r_err;
    assign length_err  = r_len;
    assign bit_count   = r_cnt;
    assign crc_out     = r_crc;
    assign o_dbg_state = r_state;

endmodule
